// File: rtl/pipelined_hybrid_adder.sv
// Pipelined adder/subtractor: BLOCK-bit CLA groups ripple inside each SEG-bit segment,
// segment carries are registered, with valid/ready handshake and ALU status flags.
module pipelined_hybrid_adder #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned BLOCK  = 4,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int unsigned SEG  = WIDTH / STAGES;
   localparam int unsigned NGRP = SEG / BLOCK;

   if ((WIDTH % STAGES) != 0 || (SEG % BLOCK) != 0) begin : g_param_check
      $error("pipelined_hybrid_adder: WIDTH must split into STAGES segments of whole BLOCK groups");
   end

   // Each stage word holds finished sum bits below its segment and raw A bits above it.
   logic             valid_q [STAGES];
   logic             valid_d [STAGES];
   logic [WIDTH-1:0] word_q  [STAGES];
   logic [WIDTH-1:0] word_d  [STAGES];
   logic [WIDTH-1:0] bop_q   [STAGES];
   logic [WIDTH-1:0] bop_d   [STAGES];
   logic             carry_q [STAGES];
   logic             carry_d [STAGES];
   logic             cmsb_q  [STAGES];
   logic             cmsb_d  [STAGES];
   logic             cin_seg [STAGES];
   logic             stall;

   // Returns the carries c[0..BLOCK] of one group in sum-of-products lookahead form.
   function automatic logic [BLOCK:0] cla_group(input logic [BLOCK-1:0] ga,
                                                input logic [BLOCK-1:0] gb,
                                                input logic             ci);
      logic [BLOCK-1:0] g;
      logic [BLOCK-1:0] p;
      logic [BLOCK:0]   c;
      logic             term;
      g    = ga & gb;
      p    = ga ^ gb;
      c    = '0;
      c[0] = ci;
      for (int unsigned j = 1; j <= BLOCK; j++) begin
         c[j] = g[j-1];
         term = p[j-1];
         for (int unsigned i = j - 1; i > 0; i--) begin
            c[j] = c[j] | (term & g[i-1]);
            term = term & p[i-1];
         end
         c[j] = c[j] | (term & ci);
      end
      return c;
   endfunction

   always_comb begin
      logic [SEG-1:0] seg_a;
      logic [SEG-1:0] seg_b;
      logic [SEG-1:0] seg_s;
      logic [BLOCK:0] cl;
      logic           carry;
      word_d[0]  = a;
      bop_d[0]   = sub ? ~b : b;
      cin_seg[0] = sub | cin;
      valid_d[0] = in_valid;
      for (int unsigned k = 1; k < STAGES; k++) begin
         word_d[k]  = word_q[k-1];
         bop_d[k]   = bop_q[k-1];
         cin_seg[k] = carry_q[k-1];
         valid_d[k] = valid_q[k-1];
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
         seg_a = word_d[k][k*SEG +: SEG];
         seg_b = bop_d[k][k*SEG +: SEG];
         seg_s = '0;
         cl    = '0;
         carry = cin_seg[k];
         for (int unsigned g = 0; g < NGRP; g++) begin
            cl = cla_group(seg_a[g*BLOCK +: BLOCK], seg_b[g*BLOCK +: BLOCK], carry);
            seg_s[g*BLOCK +: BLOCK] = seg_a[g*BLOCK +: BLOCK] ^ seg_b[g*BLOCK +: BLOCK] ^ cl[BLOCK-1:0];
            carry = cl[BLOCK];
         end
         word_d[k][k*SEG +: SEG] = seg_s;
         carry_d[k] = carry;
         cmsb_d[k]  = cl[BLOCK-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            word_q[k]  <= '0;
            bop_q[k]   <= '0;
            carry_q[k] <= 1'b0;
            cmsb_q[k]  <= 1'b0;
         end
      end else if (!stall) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            valid_q[k] <= valid_d[k];
            word_q[k]  <= word_d[k];
            bop_q[k]   <= bop_d[k];
            carry_q[k] <= carry_d[k];
            cmsb_q[k]  <= cmsb_d[k];
         end
      end
   end

   assign stall     = valid_q[STAGES-1] & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = valid_q[STAGES-1];
   assign s         = word_q[STAGES-1];
   assign cout      = carry_q[STAGES-1];
   assign ovf       = cmsb_q[STAGES-1] ^ carry_q[STAGES-1];
   assign zero      = (word_q[STAGES-1] == '0);
   assign neg       = word_q[STAGES-1][WIDTH-1];

endmodule

// File: tb/tb_pipelined_hybrid_adder.sv
// Self-checking bench for pipelined_hybrid_adder: directed vectors on the default
// configuration plus a random sweep of three other configurations against a golden model.
module tb_pipelined_hybrid_adder;

   localparam int NOPS = 10000;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic        rst;
   logic        sw_rst = 1'b1;
   logic        in_valid, in_ready, cin, sub, out_valid, out_ready;
   logic        cout, ovf, zero, neg;
   logic [31:0] a, b, s;
   logic [3:0]  flags;
   assign flags = {cout, ovf, zero, neg};

   pipelined_hybrid_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
   );

   // Flags are packed {cout, ovf, zero, neg}.
   task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                         input logic op_cin, input logic op_sub,
                         input logic [31:0] exp_s, input logic [3:0] exp_f);
      @(posedge clk); #1;
      in_valid = 1'b1; a = op_a; b = op_b; cin = op_cin; sub = op_sub; out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_acc"}, 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      check({tag, "_early"}, 64'(out_valid), 64'(0));
      @(posedge clk);
      @(negedge clk);
      check({tag, "_valid"}, 64'(out_valid), 64'(1));
      check({tag, "_s"}, 64'(s), 64'(exp_s));
      check({tag, "_flags"}, 64'(flags), 64'(exp_f));
   endtask

   initial begin
      logic [31:0] got_q[$];
      int          sent;
      int          stall_left;
      rst = 1'b1; sw_rst = 1'b1;
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; sw_rst = 1'b0;
      @(negedge clk);
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_s", 64'(s), 64'(0));
      check("rst_flags", 64'(flags), 64'(4'b0010));
      check("rst_in_ready", 64'(in_ready), 64'(1));

      run_op("add5_3",   32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 4'b0000);
      run_op("segcarry", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 4'b0000);
      run_op("wrap",     32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 4'b1010);
      run_op("sub5_7",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 4'b0001);
      run_op("addovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 4'b0101);
      run_op("subovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b1100);
      run_op("subcin",   32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 4'b1000);

      // Backpressure: 4 back-to-back adds, consumer stalls 3 cycles on the first result.
      sent = 0;
      stall_left = 3;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(posedge clk); #1;
         if (sent < 4) begin
            in_valid = 1'b1; a = 32'(sent + 1); b = 32'h10; cin = 1'b0; sub = 1'b0;
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = 1'b1;
         end
         @(negedge clk);
         if (!out_ready) begin
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_hold", 64'(s), 64'h11);
         end
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) got_q.push_back(s);
      end
      in_valid = 1'b0;
      check("bp_stalled", 64'(stall_left), 64'(0));
      check("bp_count", 64'(got_q.size()), 64'(4));
      for (int i = 0; i < got_q.size() && i < 4; i++)
         check($sformatf("bp_res%0d", i), 64'(got_q[i]), 64'(32'h11 + 32'(i)));

      // Reset with two operations in flight and the consumer stalled.
      @(posedge clk); #1;
      in_valid = 1'b1; a = 32'd1; b = 32'd2; out_ready = 1'b0;
      @(posedge clk); #1;
      a = 32'd3; b = 32'd4;
      @(posedge clk); #1;
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("rf_full", 64'(out_valid), 64'(1));
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("rf_valid", 64'(out_valid), 64'(0));
      check("rf_s", 64'(s), 64'(0));
      check("rf_flags", 64'(flags), 64'(4'b0010));
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("rf_quiet%0d", i), 64'(out_valid), 64'(0));
      end

      for (int i = 0; i < 60000 && !(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done); i++)
         @(posedge clk);
      check("sweep_done", 64'({g_sweep[0].done, g_sweep[1].done, g_sweep[2].done}), 64'(3'b111));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
      localparam int unsigned W  = (gi == 0) ? 16 : (gi == 1) ? 32 : 64;
      localparam int unsigned BK = (gi == 2) ? 8 : 4;
      localparam int unsigned ST = (gi == 0) ? 1 : (gi == 1) ? 4 : 2;

      logic         iv, ir, ov, ordy, ci, sb, co, ovf_o, zo, ng;
      logic         done = 1'b0;
      logic [W-1:0] xa, xb, xs;

      pipelined_hybrid_adder #(.WIDTH(W), .BLOCK(BK), .STAGES(ST)) u_dut (
         .clk(clk), .rst(sw_rst), .in_valid(iv), .in_ready(ir),
         .a(xa), .b(xb), .cin(ci), .sub(sb),
         .out_valid(ov), .out_ready(ordy),
         .s(xs), .cout(co), .ovf(ovf_o), .zero(zo), .neg(ng)
      );

      initial begin
         logic [W-1:0] q_s[$];
         logic [3:0]   q_f[$];
         int           q_cyc[$];
         int           q_stl[$];
         logic [W:0]   full;
         logic [W-1:0] be;
         logic         took;
         int           cyc, stalls, issued, lat;
         cyc = 0; stalls = 0; issued = 0; took = 1'b0;
         iv = 1'b0; ordy = 1'b0; xa = '0; xb = '0; ci = 1'b0; sb = 1'b0;
         wait (sw_rst == 1'b0);
         for (int guard = 0; guard < 60000 && (issued < NOPS || q_s.size() != 0); guard++) begin
            @(posedge clk); #1;
            if (issued >= NOPS) begin
               iv = 1'b0;
            end else if (!iv || took) begin
               iv = ($urandom_range(0, 3) != 0);
               xa = W'({$urandom, $urandom});
               xb = ($urandom_range(0, 7) == 0) ? xa : W'({$urandom, $urandom});
               ci = 1'($urandom_range(0, 1));
               sb = 1'($urandom_range(0, 1));
            end
            ordy = (issued < NOPS) ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            took = iv & ir;
            if (took) begin
               be   = sb ? ~xb : xb;
               full = {1'b0, xa} + {1'b0, be} + {{W{1'b0}}, (sb | ci)};
               q_s.push_back(full[W-1:0]);
               q_f.push_back({full[W], (xa[W-1] == be[W-1]) && (full[W-1] != xa[W-1]),
                              full[W-1:0] == '0, full[W-1]});
               q_cyc.push_back(cyc);
               q_stl.push_back(stalls);
               issued++;
            end
            if (ov && ordy) begin
               if (q_s.size() == 0) begin
                  check($sformatf("sw%0d_spurious", gi), 64'(1), 64'(0));
               end else begin
                  check($sformatf("sw%0d_s", gi), 64'(xs), 64'(q_s.pop_front()));
                  check($sformatf("sw%0d_flags", gi), 64'({co, ovf_o, zo, ng}), 64'(q_f.pop_front()));
                  lat = (cyc - q_cyc.pop_front()) - (stalls - q_stl.pop_front());
                  check($sformatf("sw%0d_lat", gi), 64'(lat), 64'(ST));
               end
            end
            if (ov && !ordy) stalls++;
            cyc++;
         end
         check($sformatf("sw%0d_drain", gi), 64'(q_s.size()), 64'(0));
         check($sformatf("sw%0d_issued", gi), 64'(issued), 64'(NOPS));
         done = 1'b1;
      end
   end

endmodule
